cache_ctrl: RTL and testbench

- Sequencing controller for the 2-way, 4-set, write-back/write-allocate L1 data array.
- Owns tag, valid, dirty and LRU state; performs hit/miss lookup.
- On a miss, selects a victim, writes back dirty lines and refills from next-level memory over a req/ack handshake.
- Sits between the requester (mode/index/tag/data instruction source) and the data array plus memory.

---
 rtl/cache_ctrl_if.sv | 43 ++++
 rtl/cache_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: requester handshake, data array access and next-level memory port.
// The controller uses the slave modport; the requester/array/memory side uses master.
interface cache_ctrl_if #(
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned INDEX_W = 2,
    parameter int unsigned DATA_W  = 8
);
    // Requester side
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [INDEX_W-1:0]        req_index;
    logic [TAG_W-1:0]          req_tag;
    logic [DATA_W-1:0]         req_data;
    logic                      resp_valid;
    logic                      resp_hit;
    logic [DATA_W-1:0]         resp_data;
    // Data array side
    logic [INDEX_W-1:0]        arr_index;
    logic                      arr_way;
    logic                      arr_we;
    logic [DATA_W-1:0]         arr_wdata;
    logic [DATA_W-1:0]         arr_rdata;
    // Next-level memory side
    logic                      mem_req;
    logic                      mem_we;
    logic [TAG_W+INDEX_W-1:0]  mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_ack;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_write, req_index, req_tag, req_data, arr_rdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_hit, resp_data, arr_index, arr_way, arr_we,
        output arr_wdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_index, req_tag, req_data, arr_rdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_hit, resp_data, arr_index, arr_way, arr_we,
        input  arr_wdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing controller for a 2-way set-associative write-back/write-allocate L1 data array.
// Holds tag/valid/dirty/LRU state, does the hit lookup, and on a miss writes back a dirty
// victim and refills it from next-level memory. The data array itself lives outside.
module cache_ctrl #(
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned INDEX_W = 2,
    parameter int unsigned DATA_W  = 8
) (
    input logic        clock,
    input logic        reset_n,
    cache_ctrl_if.slave bus
);
    localparam int unsigned Sets = 1 << INDEX_W;

    typedef enum logic [2:0] {StIdle, StLookup, StWb, StFill, StResp} state_e;

    state_e state_q, state_d;

    // Per-set bookkeeping; lru_q[s] names the way to evict next.
    logic [TAG_W-1:0]   tag_q [Sets][2];
    logic [1:0]         valid_q [Sets];
    logic [1:0]         dirty_q [Sets];
    logic [Sets-1:0]    lru_q;

    // Request captured at accept
    logic               write_q;
    logic [INDEX_W-1:0] index_q;
    logic [TAG_W-1:0]   rtag_q;
    logic [DATA_W-1:0]  wdata_q;

    logic               victim_q;
    logic               resp_hit_q;
    logic [DATA_W-1:0]  resp_data_q;

    logic hit0, hit1, hit, hit_way, victim_sel, victim_dirty;
    logic mem_done;

    // Tag compare and victim choice for the latched set
    always_comb begin
        hit0 = valid_q[index_q][0] && (tag_q[index_q][0] == rtag_q);
        hit1 = valid_q[index_q][1] && (tag_q[index_q][1] == rtag_q);
        hit = hit0 | hit1;
        hit_way = hit1;
        if (!valid_q[index_q][0]) begin
            victim_sel = 1'b0;
        end else if (!valid_q[index_q][1]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = lru_q[index_q];
        end
        victim_dirty = valid_q[index_q][victim_sel] && dirty_q[index_q][victim_sel];
        // Acks are only meaningful while a memory request is outstanding
        mem_done = bus.mem_ack && ((state_q == StWb) || (state_q == StFill));
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.req_valid) state_d = StLookup;
            StLookup: begin
                if (hit) begin
                    state_d = StResp;
                end else if (victim_dirty) begin
                    state_d = StWb;
                end else begin
                    state_d = StFill;
                end
            end
            StWb:     if (mem_done) state_d = StFill;
            StFill:   if (mem_done) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.resp_hit   = (state_q == StResp) && resp_hit_q;
        bus.resp_data  = (state_q == StResp) ? resp_data_q : '0;
        bus.arr_index  = index_q;
        bus.arr_way    = (state_q == StLookup) ? hit_way : victim_q;
        bus.arr_we     = 1'b0;
        bus.arr_wdata  = write_q ? wdata_q : bus.mem_rdata;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        unique case (state_q)
            StLookup: bus.arr_we = hit && write_q;
            StWb: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {tag_q[index_q][victim_q], index_q};
                // Array is not written during write-back, so this read is stable
                bus.mem_wdata = bus.arr_rdata;
            end
            StFill: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {rtag_q, index_q};
                bus.arr_we   = bus.mem_ack;
            end
            default: ;
        endcase
    end

    // Request latch, bookkeeping updates and response capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < Sets; i++) begin
                tag_q[i][0] <= '0;
                tag_q[i][1] <= '0;
                valid_q[i]  <= '0;
                dirty_q[i]  <= '0;
            end
            lru_q       <= '0;
            write_q     <= 1'b0;
            index_q     <= '0;
            rtag_q      <= '0;
            wdata_q     <= '0;
            victim_q    <= 1'b0;
            resp_hit_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            if ((state_q == StIdle) && bus.req_valid) begin
                write_q <= bus.req_write;
                index_q <= bus.req_index;
                rtag_q  <= bus.req_tag;
                wdata_q <= bus.req_data;
            end
            if (state_q == StLookup) begin
                victim_q   <= victim_sel;
                resp_hit_q <= hit;
                if (hit) begin
                    lru_q[index_q] <= ~hit_way;
                    if (write_q) begin
                        dirty_q[index_q][hit_way] <= 1'b1;
                        resp_data_q <= wdata_q;
                    end else begin
                        resp_data_q <= bus.arr_rdata;
                    end
                end
            end
            if ((state_q == StFill) && mem_done) begin
                tag_q[index_q][victim_q]   <= rtag_q;
                valid_q[index_q][victim_q] <= 1'b1;
                dirty_q[index_q][victim_q] <= write_q;
                lru_q[index_q]             <= ~victim_q;
                resp_data_q                <= write_q ? wdata_q : bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: a directed vector table, a reset-abort sequence and a random run
// checked against a recency-stamp cache model. The bench models the data array and memory.
module tb_cache_ctrl;
    localparam int TW = 8;
    localparam int IW = 2;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cache_ctrl_if #(.TAG_W(TW), .INDEX_W(IW), .DATA_W(DW)) bus ();

    cache_ctrl #(.TAG_W(TW), .INDEX_W(IW), .DATA_W(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Data array: combinational read, write at clock edge
    logic [DW-1:0] arr_mem [4][2];
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                arr_mem[i][0] <= '0;
                arr_mem[i][1] <= '0;
            end
        end else if (bus.arr_we) begin
            arr_mem[bus.arr_index][bus.arr_way] <= bus.arr_wdata;
        end
    end
    assign bus.arr_rdata = arr_mem[bus.arr_index][bus.arr_way];

    // Next-level memory contents
    logic [DW-1:0] mem_model [1024];

    typedef struct {
        bit   wr;
        int   idx;
        int   tag;
        int   data;
        int   delay;
        bit   e_hit;
        int   e_data;
        int   e_lat;
        bit   e_wb;
        int   e_wb_addr;
        int   e_wb_data;
        int   e_fill_addr;
    } vec_t;

    typedef struct {
        int hit;
        int data;
        int lat;
        int wb_addr;
        int wb_data;
        int fill_addr;
        int unstable;
        int ready_busy;
    } res_t;

    int checks = 0;
    int failures = 0;

    // Reference model: per-line contents plus a last-use timestamp per way
    bit  m_valid [4][2];
    bit  m_dirty [4][2];
    int  m_tag   [4][2];
    int  m_data  [4][2];
    int  m_stamp [4][2];
    int  now;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic mem_init();
        for (int a = 0; a < 1024; a++) mem_model[a] = DW'(a[7:0] ^ 8'h15);
    endtask

    task automatic model_reset();
        now = 0;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w] = 0;
                m_data[s][w] = 0;
                m_stamp[s][w] = 0;
            end
        end
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Cache rules applied directly: hit updates data/recency, miss evicts an invalid or
    // least recently used line, writing it back first if modified.
    task automatic predict(input bit wr, input int idx, input int tag, input int data,
                           input int delay, output vec_t e);
        bit h;
        int w;
        int faddr;
        now++;
        h = 1'b0;
        w = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_valid[idx][i] && m_tag[idx][i] == tag) begin
                h = 1'b1;
                w = i;
            end
        end
        e.wr = wr; e.idx = idx; e.tag = tag; e.data = data; e.delay = delay;
        e.e_hit = h; e.e_wb = 1'b0; e.e_wb_addr = -1; e.e_wb_data = 0;
        if (h) begin
            if (wr) begin
                m_data[idx][w] = data;
                m_dirty[idx][w] = 1'b1;
            end
            e.e_data = m_data[idx][w];
            e.e_lat = 2;
            e.e_fill_addr = -1;
        end else begin
            if (!m_valid[idx][0]) w = 0;
            else if (!m_valid[idx][1]) w = 1;
            else w = (m_stamp[idx][0] < m_stamp[idx][1]) ? 0 : 1;
            if (m_valid[idx][w] && m_dirty[idx][w]) begin
                e.e_wb = 1'b1;
                e.e_wb_addr = (m_tag[idx][w] << IW) | idx;
                e.e_wb_data = m_data[idx][w];
            end
            faddr = (tag << IW) | idx;
            e.e_fill_addr = faddr;
            m_data[idx][w] = wr ? data : int'(mem_model[faddr]);
            m_dirty[idx][w] = wr;
            m_valid[idx][w] = 1'b1;
            m_tag[idx][w] = tag;
            e.e_data = m_data[idx][w];
            e.e_lat = e.e_wb ? (4 + 2 * delay) : (3 + delay);
        end
        m_stamp[idx][w] = now;
    endtask

    // Issue one request, act as memory (ack after 'delay' waiting cycles per phase),
    // and record what the controller did. Latency counted in cycles after the accept edge.
    task automatic run_req(input bit wr, input int idx, input int tag, input int data,
                           input int delay, input bit stray, output res_t r);
        int k;
        int waitc;
        bit phase_on;
        bit done;
        logic [TW+IW-1:0] p_addr;
        logic p_we;
        logic [DW-1:0] p_wdata;
        r.hit = 0; r.data = 0; r.lat = -1; r.wb_addr = -1; r.wb_data = 0;
        r.fill_addr = -1; r.unstable = 0; r.ready_busy = 0;
        @(negedge clock);
        check("ready_idle", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_index = IW'(idx);
        bus.req_tag = TW'(tag);
        bus.req_data = DW'(data);
        @(posedge clock);
        @(negedge clock);
        // Scramble request inputs; they must be ignored until the next accept
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_index = IW'($urandom_range(0, 3));
        bus.req_tag = TW'($urandom_range(0, 255));
        bus.req_data = DW'($urandom_range(0, 255));
        k = 1; waitc = 0; phase_on = 1'b0; done = 1'b0;
        p_addr = '0; p_we = 1'b0; p_wdata = '0;
        while (!done && k <= 80) begin
            bus.mem_ack = 1'b0;
            bus.mem_rdata = DW'($urandom_range(0, 255));
            #1;
            if (bus.req_ready) r.ready_busy++;
            if (bus.resp_valid) begin
                r.hit = bus.resp_hit;
                r.data = bus.resp_data;
                r.lat = k;
                done = 1'b1;
            end else if (bus.mem_req) begin
                if (!phase_on) begin
                    phase_on = 1'b1;
                    waitc = 0;
                    p_we = bus.mem_we;
                    p_addr = bus.mem_addr;
                    p_wdata = bus.mem_wdata;
                    if (bus.mem_we) begin
                        r.wb_addr = bus.mem_addr;
                        r.wb_data = bus.mem_wdata;
                    end else begin
                        r.fill_addr = bus.mem_addr;
                    end
                end else if (bus.mem_we !== p_we || bus.mem_addr !== p_addr ||
                             (p_we && bus.mem_wdata !== p_wdata)) begin
                    r.unstable++;
                end
                if (waitc == delay) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_model[bus.mem_addr];
                    phase_on = 1'b0;
                end else begin
                    waitc++;
                end
            end else if (stray && $urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
            end
            if (!done) begin
                @(negedge clock);
                k++;
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic compare(input string nm, input vec_t e, input res_t r);
        check({nm, " resp_hit"}, r.hit, int'(e.e_hit));
        check({nm, " resp_data"}, r.data, e.e_data);
        check({nm, " latency"}, r.lat, e.e_lat);
        check({nm, " wb_addr"}, r.wb_addr, e.e_wb_addr);
        if (e.e_wb) check({nm, " wb_data"}, r.wb_data, e.e_wb_data);
        check({nm, " fill_addr"}, r.fill_addr, e.e_fill_addr);
        check({nm, " mem_stable"}, r.unstable, 0);
        check({nm, " ready_busy"}, r.ready_busy, 0);
    endtask

    vec_t tbl [13];
    vec_t e;
    res_t r;
    int fill_seen;
    int resp_seen;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_index = '0;
        bus.req_tag = '0;
        bus.req_data = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        mem_init();
        model_reset();

        // wr idx tag data delay | hit data lat wb wb_addr wb_data fill_addr
        tbl[0]  = '{1'b1, 3, 'h00, 'h01, 0, 1'b0, 'h01, 3,  1'b0, -1,    0,     'h003};
        tbl[1]  = '{1'b1, 3, 'h00, 'hFF, 0, 1'b1, 'hFF, 2,  1'b0, -1,    0,     -1};
        tbl[2]  = '{1'b0, 3, 'h00, 'h00, 0, 1'b1, 'hFF, 2,  1'b0, -1,    0,     -1};
        tbl[3]  = '{1'b0, 3, 'h07, 'h00, 0, 1'b0, 'h0A, 3,  1'b0, -1,    0,     'h01F};
        tbl[4]  = '{1'b0, 3, 'h09, 'h00, 5, 1'b0, 'h32, 14, 1'b1, 'h003, 'hFF,  'h027};
        tbl[5]  = '{1'b0, 3, 'h07, 'h00, 0, 1'b1, 'h0A, 2,  1'b0, -1,    0,     -1};
        tbl[6]  = '{1'b1, 3, 'h0B, 'h5C, 1, 1'b0, 'h5C, 4,  1'b0, -1,    0,     'h02F};
        tbl[7]  = '{1'b0, 3, 'h09, 'h00, 0, 1'b0, 'h32, 3,  1'b0, -1,    0,     'h027};
        tbl[8]  = '{1'b0, 3, 'h10, 'h00, 0, 1'b0, 'h56, 4,  1'b1, 'h02F, 'h5C,  'h043};
        tbl[9]  = '{1'b0, 3, 'h0B, 'h00, 0, 1'b0, 'h5C, 3,  1'b0, -1,    0,     'h02F};
        tbl[10] = '{1'b0, 0, 'hAA, 'h00, 0, 1'b0, 'hBD, 3,  1'b0, -1,    0,     'h2A8};
        tbl[11] = '{1'b1, 1, 'h33, 'h77, 2, 1'b0, 'h77, 5,  1'b0, -1,    0,     'h0CD};
        tbl[12] = '{1'b0, 1, 'h33, 'h00, 0, 1'b1, 'h77, 2,  1'b0, -1,    0,     -1};

        // Reset values, checked while reset is asserted and just after release
        #2;
        check("rst resp_valid", int'(bus.resp_valid), 0);
        check("rst mem_req", int'(bus.mem_req), 0);
        do_reset();
        #1;
        check("rst req_ready", int'(bus.req_ready), 1);
        check("rst resp_hit", int'(bus.resp_hit), 0);
        check("rst resp_data", int'(bus.resp_data), 0);
        check("rst arr_we", int'(bus.arr_we), 0);
        check("rst mem_we", int'(bus.mem_we), 0);

        for (int i = 0; i < 13; i++) begin
            run_req(tbl[i].wr, tbl[i].idx, tbl[i].tag, tbl[i].data, tbl[i].delay, 1'b0, r);
            compare($sformatf("vec%0d", i), tbl[i], r);
        end

        // Reset during refill: request dropped at once, no response, line lost
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_index = 2'd3;
        bus.req_tag = 8'h00;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        fill_seen = 0;
        for (int i = 0; i < 6 && fill_seen == 0; i++) begin
            #1;
            if (bus.mem_req && !bus.mem_we) fill_seen = 1;
            else @(negedge clock);
        end
        check("abort fill_reached", fill_seen, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort mem_req", int'(bus.mem_req), 0);
        resp_seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.resp_valid) resp_seen++;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clock);
            #1;
            if (bus.resp_valid) resp_seen++;
        end
        check("abort no_resp", resp_seen, 0);
        // Memory at 0x003 holds the earlier write-back of 0xFF
        e = '{1'b0, 3, 'h00, 'h00, 0, 1'b0, 'hFF, 3, 1'b0, -1, 0, 'h003};
        run_req(e.wr, e.idx, e.tag, e.data, e.delay, 1'b0, r);
        compare("after_abort", e, r);

        // Random traffic against the reference model
        do_reset();
        mem_init();
        model_reset();
        for (int n = 0; n < 150; n++) begin
            predict(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)), e);
            run_req(e.wr, e.idx, e.tag, e.data, e.delay, 1'b1, r);
            compare($sformatf("rnd%0d", n), e, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
